user_axil_ctrl_regs: RTL

AXI4-Lite responder terminating the shell's control master inside the user partition. Provides a 4 KiB control/status register window with ID, scratch, control, a free-running 64-bit cycle counter, and optional HBM health status. Has one outstanding write and one outstanding read. Runs entirely in the shell AXI clock domain.

---
 rtl/user_axil_ctrl_regs.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/user_axil_ctrl_regs.sv
// user_axil_ctrl_regs: AXI4-Lite control/status register window (ID, scratch, control, 64-bit cycle counter).
// Defining USER_CTRL_HBM_MON_EN adds the HBM_STATUS register at 0x020.
module user_axil_ctrl_regs #(
  parameter logic [31:0] USER_ID      = 32'h5553_5231,
  parameter logic [31:0] USER_VERSION = 32'h0001_0000,
  parameter int          DECODE_BITS  = 12
) (
  input  logic        shell_axi_clk,
  input  logic        shell_rstn,
  input  logic [31:0] shell_axil_ctrl_awaddr,
  input  logic [2:0]  shell_axil_ctrl_awprot,
  input  logic        shell_axil_ctrl_awvalid,
  output logic        shell_axil_ctrl_awready,
  input  logic [31:0] shell_axil_ctrl_wdata,
  input  logic [3:0]  shell_axil_ctrl_wstrb,
  input  logic        shell_axil_ctrl_wvalid,
  output logic        shell_axil_ctrl_wready,
  output logic [1:0]  shell_axil_ctrl_bresp,
  output logic        shell_axil_ctrl_bvalid,
  input  logic        shell_axil_ctrl_bready,
  input  logic [31:0] shell_axil_ctrl_araddr,
  input  logic [2:0]  shell_axil_ctrl_arprot,
  input  logic        shell_axil_ctrl_arvalid,
  output logic        shell_axil_ctrl_arready,
  output logic [31:0] shell_axil_ctrl_rdata,
  output logic [1:0]  shell_axil_ctrl_rresp,
  output logic        shell_axil_ctrl_rvalid,
  input  logic        shell_axil_ctrl_rready,
  output logic [31:0] user_ctrl,
  input  logic        user_hbm_cattrip,
  input  logic [6:0]  user_hbm_temp_0,
  input  logic [6:0]  user_hbm_temp_1
);
  localparam int AW = DECODE_BITS - 2;
  localparam logic [AW-1:0] A_ID = AW'(0), A_VER = AW'(1), A_SCR = AW'(2), A_CTL = AW'(3),
                            A_LO = AW'(4), A_HI = AW'(5), A_HBM = AW'(8);
  logic          r_rdy_en, r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic [1:0]    r_bresp, r_rresp;
  logic [AW-1:0] r_awaddr;
  logic [3:0]    r_wstrb;
  logic [31:0]   r_wdata, r_rdata, r_scratch, r_control, r_cycle_hi;
  logic [63:0]   r_cycle;
  logic [AW-1:0] w_ra;
  logic [31:0]   w_rd_data, w_hbm_status;
  logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_hbm_map, w_rd_ok, w_wr_ok;
  logic          w_unused_axi;
  assign w_unused_axi = ^{shell_axil_ctrl_awprot, shell_axil_ctrl_arprot,
                          shell_axil_ctrl_awaddr[31:DECODE_BITS], shell_axil_ctrl_awaddr[1:0],
                          shell_axil_ctrl_araddr[31:DECODE_BITS], shell_axil_ctrl_araddr[1:0]};
  assign shell_axil_ctrl_awready = r_rdy_en && !r_aw_held && !r_bvalid;
  assign shell_axil_ctrl_wready  = r_rdy_en && !r_w_held && !r_bvalid;
  assign shell_axil_ctrl_arready = r_rdy_en && !r_rvalid;
  assign shell_axil_ctrl_bvalid  = r_bvalid;
  assign shell_axil_ctrl_bresp   = r_bresp;
  assign shell_axil_ctrl_rvalid  = r_rvalid;
  assign shell_axil_ctrl_rresp   = r_rresp;
  assign shell_axil_ctrl_rdata   = r_rdata;
  assign user_ctrl               = r_control;
  assign w_aw_hs  = shell_axil_ctrl_awvalid && shell_axil_ctrl_awready;
  assign w_w_hs   = shell_axil_ctrl_wvalid && shell_axil_ctrl_wready;
  assign w_ar_hs  = shell_axil_ctrl_arvalid && shell_axil_ctrl_arready;
  assign w_commit = r_aw_held && r_w_held;
  assign w_ra     = shell_axil_ctrl_araddr[DECODE_BITS-1:2];
  assign w_rd_ok  = (w_ra <= A_HI) || (w_hbm_map && w_ra == A_HBM);
  assign w_wr_ok  = (r_awaddr <= A_HI) || (w_hbm_map && r_awaddr == A_HBM);
  assign w_rd_data = w_ra == A_ID  ? USER_ID :
                     w_ra == A_VER ? USER_VERSION :
                     w_ra == A_SCR ? r_scratch :
                     w_ra == A_CTL ? r_control :
                     w_ra == A_LO  ? r_cycle[31:0] :
                     w_ra == A_HI  ? r_cycle_hi :
                     (w_hbm_map && w_ra == A_HBM) ? w_hbm_status : 32'd0;
`ifdef USER_CTRL_HBM_MON_EN
  logic [6:0] r_t0_s1, r_t0_s2, r_t1_s1, r_t1_s2;
  logic       r_ct_s1, r_ct_s2, r_sticky, w_hbm_clr;
  assign w_hbm_map    = 1'b1;
  assign w_hbm_clr    = w_commit && r_awaddr == A_HBM && r_wstrb[2] && r_wdata[17];
  assign w_hbm_status = {14'd0, r_sticky, r_ct_s2, 1'b0, r_t1_s2, 1'b0, r_t0_s2};
  always_ff @(posedge shell_axi_clk or negedge shell_rstn)
    if (!shell_rstn) begin
      {r_t0_s1, r_t0_s2, r_t1_s1, r_t1_s2} <= '0;
      {r_ct_s1, r_ct_s2, r_sticky} <= '0;
    end else begin
      {r_t0_s2, r_t0_s1} <= {r_t0_s1, user_hbm_temp_0};
      {r_t1_s2, r_t1_s1} <= {r_t1_s1, user_hbm_temp_1};
      {r_ct_s2, r_ct_s1} <= {r_ct_s1, user_hbm_cattrip};
      r_sticky <= r_ct_s2 ? 1'b1 : (w_hbm_clr ? 1'b0 : r_sticky);
    end
`else
  logic w_unused_hbm;
  assign w_hbm_map    = 1'b0;
  assign w_hbm_status = 32'd0;
  assign w_unused_hbm = ^{user_hbm_cattrip, user_hbm_temp_0, user_hbm_temp_1};
`endif
  always_ff @(posedge shell_axi_clk or negedge shell_rstn)
    if (!shell_rstn) begin
      {r_rdy_en, r_aw_held, r_w_held, r_bvalid, r_rvalid} <= '0;
      {r_bresp, r_rresp} <= '0;
      r_awaddr   <= '0;
      r_wstrb    <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_scratch  <= '0;
      r_control  <= '0;
      r_cycle    <= '0;
      r_cycle_hi <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      r_cycle  <= r_cycle + 64'd1;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= shell_axil_ctrl_awaddr[DECODE_BITS-1:2];
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= shell_axil_ctrl_wdata;
        r_wstrb  <= shell_axil_ctrl_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_ok ? 2'b00 : 2'b11;
        for (int i = 0; i < 4; i++)
          if (r_wstrb[i]) begin
            if (r_awaddr == A_SCR) r_scratch[8*i +: 8] <= r_wdata[8*i +: 8];
            if (r_awaddr == A_CTL) r_control[8*i +: 8] <= r_wdata[8*i +: 8];
          end
      end else if (r_bvalid && shell_axil_ctrl_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_ok ? 2'b00 : 2'b11;
        // Snapshot the high word so a following CYCLE_HI read matches this low word.
        if (w_ra == A_LO) r_cycle_hi <= r_cycle[63:32];
      end else if (r_rvalid && shell_axil_ctrl_rready) begin
        r_rvalid <= 1'b0;
      end
    end
endmodule
